// File: rtl/pisa_debug_pkg.sv
// Shared types and constants for the workbench debug/stepping logic.
// Holds the step sequencer state encoding and the default button debounce length.
package pisa_debug_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        BURST = 2'd1,
        RUN   = 2'd2,
        BREAK = 2'd3
    } step_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 2_000_000;

    // Bits needed to hold a counter that saturates at max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus saturating hold counter for a board push button.
// Emits a single-cycle press pulse once per hold, when the counter reaches DEBOUNCE_CYCLES.
module button_debounce
    import pisa_debug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Saturation at CNT_MAX is what limits the pulse to one per hold.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d   = cnt_q + 1'b1;
            press_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/step_controller.sv
// Clock-enable sequencer for the core: free-run, debounced single/burst stepping and
// address breakpoint halting, with halt status and an issued-step counter for the LEDs.
module step_controller
    import pisa_debug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned BURST_W         = 8,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic               run_mode,
    input  logic [BURST_W-1:0] burst_count,
    input  logic               bp_enable,
    input  logic [31:0]        bp_address,
    input  logic [31:0]        core_address,
    output logic               core_en,
    output logic               halted,
    output logic               at_break,
    output logic [COUNT_W-1:0] step_count,
    output logic [1:0]         dbg_state
);

    step_state_t        state_q;
    step_state_t        state_d;
    logic [BURST_W-1:0] remaining_q;
    logic [BURST_W-1:0] remaining_d;
    logic               skip_bp_q;
    logic               skip_bp_d;
    logic [COUNT_W-1:0] step_count_q;

    logic               press;
    logic               bp_hit;
    logic               core_en_c;
    logic [BURST_W-1:0] burst_len;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    // Combinational so the enable drops in the same cycle the address matches.
    assign bp_hit    = bp_enable && (core_address == bp_address);
    assign burst_len = (burst_count == '0) ? BURST_W'(1) : burst_count;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        skip_bp_d   = skip_bp_q;
        core_en_c   = 1'b0;
        case (state_q)
            HALT: begin
                if (run_mode) begin
                    state_d = RUN;
                end else if (press) begin
                    state_d     = BURST;
                    remaining_d = burst_len;
                    skip_bp_d   = 1'b0;
                end
            end
            BURST: begin
                core_en_c = !(bp_hit && !skip_bp_q);
                if (!core_en_c) begin
                    state_d = BREAK;
                end else begin
                    remaining_d = remaining_q - 1'b1;
                    skip_bp_d   = 1'b0;
                    if (remaining_q == BURST_W'(1)) begin
                        state_d = run_mode ? RUN : HALT;
                    end
                end
            end
            RUN: begin
                core_en_c = !bp_hit;
                if (bp_hit) begin
                    state_d = BREAK;
                end else if (!run_mode) begin
                    state_d = HALT;
                end
            end
            BREAK: begin
                // A single step with the breakpoint masked moves the core off the match.
                if (press) begin
                    state_d     = BURST;
                    remaining_d = BURST_W'(1);
                    skip_bp_d   = 1'b1;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HALT;
            remaining_q  <= '0;
            skip_bp_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            skip_bp_q   <= skip_bp_d;
            if (core_en_c) begin
                step_count_q <= step_count_q + 1'b1;
            end
        end
    end

    assign core_en    = core_en_c;
    assign halted     = (state_q == HALT) || (state_q == BREAK);
    assign at_break   = (state_q == BREAK);
    assign step_count = step_count_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/step_controller.md
# step_controller

Clock-enable sequencer for the processor core in the workbench top level. Replaces the gated manual-clock scheme: the core, memory and output map run on the board clock, and this block drives a single clock-enable that allows free-run, debounced single/burst stepping from a button, and halting on an address breakpoint. The block also exports halt status and an issued-step counter for the debug LEDs.

## Interface
- DEBOUNCE_CYCLES, 2_000_000: cycles the synchronised button must stay high before a press registers.
- BURST_W, 8: width of the burst-length input.
- COUNT_W, 16: width of the issued-step counter.

- clk  in  1: board clock; the only clock.
- rst  in  1: asynchronous, active-high reset.
- btn  in  1: raw, asynchronous step button.
- run_mode  in  1: 1 selects free-run, 0 selects stepping.
- burst_count  in  BURST_W: core cycles issued per press; 0 is treated as 1.
- bp_enable  in  1: enables the breakpoint.
- bp_address  in  32: breakpoint address.
- core_address  in  32: the core's current address bus.
- core_en  out  1: core/memory clock enable.
- halted  out  1: 1 in HALT or BREAK.
- at_break  out  1: 1 in BREAK.
- step_count  out  COUNT_W: number of cycles in which core_en was 1; wraps.

## Operation
- Button path:
  - btn passes through a 2-flop synchroniser.
  - Debounce counter increments while the synchronised level is 1 and saturates at DEBOUNCE_CYCLES.
  - The counter clears on the first cycle the synchronised level is 0.
  - A one-cycle `press` pulse fires on the cycle the counter reaches DEBOUNCE_CYCLES. There is exactly one pulse per hold.
- bp_hit = bp_enable && (core_address == bp_address), combinational.
- States:
  - HALT:
    - core_en=0.
    - run_mode=1 → RUN.
    - else press → BURST, with remaining = max(burst_count,1) and skip_bp=0.
  - BURST:
    - core_en = !(bp_hit && !skip_bp).
    - If bp_hit && !skip_bp → BREAK, remaining unchanged.
    - Else remaining decrements and skip_bp clears.
    - When remaining==1 on an enabled cycle → RUN if run_mode, else HALT.
  - RUN:
    - core_en = !bp_hit.
    - bp_hit → BREAK (takes priority over run_mode falling).
    - else run_mode=0 → HALT.
  - BREAK:
    - core_en=0. run_mode has no effect.
    - press → BURST, with remaining=1 and skip_bp=1. This steps past the breakpoint address.
- Ignored presses: a press in BURST or RUN is ignored, not queued.
- step_count increments on every cycle with core_en=1, modulo 2^COUNT_W.
- Reset values: state=HALT, core_en=0, halted=1, at_break=0, step_count=0, remaining=0, skip_bp=0, synchroniser=0, debounce counter=0.
- Reset mid-burst or mid-run aborts immediately. No enable is issued during reset.

## Timing
- Button to first core_en: the raw btn rise takes 2 sync cycles + DEBOUNCE_CYCLES cycles to produce `press`. core_en is high starting the cycle after `press`.
- A burst of N gives exactly N consecutive core_en cycles when no breakpoint hits.
- Breakpoint: core_en drops in the same cycle core_address matches (combinational). BREAK is entered on the next edge. The matching instruction is not executed.
- run_mode changes are sampled each cycle with no synchronisation. The switch input has its own 2-flop synchroniser at top level, outside this block.
- state, remaining, skip_bp and step_count are registered. core_en, halted and at_break are decoded from state plus bp_hit.

## Structure
- Shared package pisa_debug_pkg holds:
  - the typedef enum logic [1:0] {HALT, BURST, RUN, BREAK} step_state_t;
  - the default DEBOUNCE_CYCLES constant.
- One sub-module: button_debounce.
  - Contains the synchroniser and saturating counter.
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst, btn → press.
  - Reused for other board buttons.

## Test plan
Benches use DEBOUNCE_CYCLES=4.
- Reset: assert rst mid-RUN → core_en=0, halted=1 and step_count=0 asynchronously; after release, state is HALT.
- Debounce: btn high for 3 synced cycles then low, then high for 10 cycles → no press from the first pulse, exactly one press from the second, then exactly one core_en cycle with burst_count=0.
- Burst: burst_count=5, one press → exactly 5 consecutive core_en cycles, step_count=5, return to HALT. A second press during the burst adds nothing.
- Breakpoint in RUN: bp_address=0x10, bp_enable=1, core_address reaches 0x10 → core_en=0 in that cycle, then at_break=1. A press then gives 1 core_en cycle with core_address=0x10 and returns to HALT (run_mode=0).
- Priority: in RUN, run_mode falls in the same cycle bp_hit=1 → BREAK, not HALT.
- Wrap: COUNT_W=4, run 17 cycles in RUN → step_count=1.
